// File: rtl/eth_mac_tx_arbiter.sv
// eth_mac_tx_arbiter: frame-level round-robin arbiter onto the MAC tx stream, quiescing across link-speed changes
module eth_mac_tx_arbiter #(
  parameter int S_COUNT = 4,
  parameter int DATA_WIDTH = 8,
  parameter int SETTLE_CYCLES = 256
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [S_COUNT*DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [S_COUNT-1:0]            s_axis_tvalid,
  output logic [S_COUNT-1:0]            s_axis_tready,
  input  logic [S_COUNT-1:0]            s_axis_tlast,
  input  logic [S_COUNT-1:0]            s_axis_tuser,
  output logic [DATA_WIDTH-1:0]         m_axis_tdata,
  output logic                          m_axis_tvalid,
  input  logic                          m_axis_tready,
  output logic                          m_axis_tlast,
  output logic                          m_axis_tuser,
  input  logic [1:0]                    speed,
  input  logic                          enable,
  output logic                          grant_valid,
  output logic [$clog2(S_COUNT)-1:0]    grant_index,
  output logic                          settling
);
  localparam int IW = $clog2(S_COUNT);
  localparam int CW = SETTLE_CYCLES > 1 ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(SETTLE_CYCLES - 1);
  typedef enum logic [1:0] {IDLE, ACTIVE, SETTLE} state_t;
  state_t state;
  logic [IW-1:0] last_grant, sel, idx;
  logic [CW-1:0] cnt;
  logic [1:0] speed_reg;
  logic pending, found, active, frame_done, speed_chg;
  // Outputs are forced idle while rst_n is low so no beat is accepted during reset.
  assign active = rst_n && state == ACTIVE;
  assign m_axis_tvalid = active && s_axis_tvalid[grant_index];
  assign m_axis_tlast = active && s_axis_tlast[grant_index];
  assign m_axis_tuser = active && s_axis_tuser[grant_index];
  assign m_axis_tdata = active ? s_axis_tdata[grant_index*DATA_WIDTH +: DATA_WIDTH] : '0;
  assign s_axis_tready = active && m_axis_tready ? (S_COUNT)'(1) << grant_index : '0;
  assign frame_done = m_axis_tvalid && m_axis_tready && m_axis_tlast;
  assign speed_chg = speed != speed_reg;
  // Round-robin pick: first valid source searching upward from last_grant+1 with wrap.
  always_comb begin
    sel = '0;
    idx = '0;
    found = 1'b0;
    for (int k = 0; k < S_COUNT; k++) begin
      idx = IW'((int'(last_grant) + 1 + k) % S_COUNT);
      if (!found && s_axis_tvalid[idx]) begin
        sel = idx;
        found = 1'b1;
      end
    end
  end
  // Arbitration FSM: grant, hold until tlast, and enforce settle time after speed changes.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      grant_valid <= 1'b0;
      grant_index <= '0;
      last_grant <= IW'(S_COUNT - 1);
      speed_reg <= 2'b10;
      pending <= 1'b0;
      settling <= 1'b0;
      cnt <= '0;
    end else begin
      case (state)
        IDLE:
          if (speed_chg) begin
            speed_reg <= speed;
            cnt <= CNT_MAX;
            settling <= 1'b1;
            state <= SETTLE;
          end else if (enable && found) begin
            grant_index <= sel;
            grant_valid <= 1'b1;
            state <= ACTIVE;
          end
        ACTIVE: begin
          if (speed_chg) begin
            speed_reg <= speed;
            pending <= 1'b1;
          end
          if (frame_done) begin
            last_grant <= grant_index;
            grant_valid <= 1'b0;
            if (pending || speed_chg) begin
              pending <= 1'b0;
              cnt <= CNT_MAX;
              settling <= 1'b1;
              state <= SETTLE;
            end else begin
              state <= IDLE;
            end
          end
        end
        SETTLE:
          if (speed_chg) begin
            speed_reg <= speed;
            cnt <= CNT_MAX;
          end else if (cnt == '0) begin
            settling <= 1'b0;
            state <= IDLE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_eth_mac_tx_arbiter.sv
// tb_eth_mac_tx_arbiter: vector table plus scoreboarded sequences for the tx arbiter
module tb_eth_mac_tx_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [31:0] s_axis_tdata = '0;
  logic [3:0] s_axis_tvalid = '0, s_axis_tready, s_axis_tlast = '0, s_axis_tuser = '0;
  logic [7:0] m_axis_tdata;
  logic m_axis_tvalid, m_axis_tlast, m_axis_tuser;
  logic m_axis_tready = 1'b1;
  logic [1:0] speed = 2'b10;
  logic enable = 1'b1;
  logic grant_valid, settling;
  logic [1:0] grant_index;
  int n_vec = 0, n_err = 0;
  logic [3:0] acc = '0;
  logic [9:0] src_q [4][$];
  logic [9:0] exp_q [$];
  typedef struct {
    logic has_prev;
    logic [1:0] prev;
    logic [3:0] mask;
    logic en;
    logic exp_gv;
    logic [1:0] exp_idx;
  } vec_t;
  vec_t vecs [11];

  always #5 clk = ~clk;

  eth_mac_tx_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .s_axis_tlast(s_axis_tlast), .s_axis_tuser(s_axis_tuser),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .m_axis_tlast(m_axis_tlast), .m_axis_tuser(m_axis_tuser),
    .speed(speed), .enable(enable),
    .grant_valid(grant_valid), .grant_index(grant_index), .settling(settling)
  );

  // Scoreboard: every beat the MAC accepts is compared with the next expected beat.
  always @(negedge clk) begin
    logic [9:0] got, want;
    acc = s_axis_tvalid & s_axis_tready;
    if (m_axis_tvalid && m_axis_tready) begin
      got = {m_axis_tuser, m_axis_tlast, m_axis_tdata};
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL beat: unexpected beat %h, none expected", got);
      end else begin
        want = exp_q.pop_front();
        if (got !== want) begin
          n_err++;
          $display("FAIL beat: got %h expected %h", got, want);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    n_vec++;
    if (act !== want) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, want);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < 4; i++) begin
      if (src_q[i].size() > 0) begin
        s_axis_tvalid[i] = 1'b1;
        s_axis_tdata[i*8 +: 8] = src_q[i][0][7:0];
        s_axis_tlast[i] = src_q[i][0][8];
        s_axis_tuser[i] = src_q[i][0][9];
      end else begin
        s_axis_tvalid[i] = 1'b0;
        s_axis_tdata[i*8 +: 8] = 8'h00;
        s_axis_tlast[i] = 1'b0;
        s_axis_tuser[i] = 1'b0;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) if (acc[i]) src_q[i].delete(0);
    drive();
  endtask

  task automatic push_frame(input int s, input int n, input logic [7:0] base, input int nexp);
    logic [9:0] beat;
    for (int b = 0; b < n; b++) begin
      beat = {(b == n - 1) && (s % 2 == 1), b == n - 1, 8'(base + b)};
      src_q[s].push_back(beat);
      if (b < nexp) exp_q.push_back(beat);
    end
    drive();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    speed = 2'b10;
    enable = 1'b1;
    m_axis_tready = 1'b1;
    tick();
    tick();
    for (int i = 0; i < 4; i++) src_q[i].delete();
    exp_q.delete();
    rst_n = 1'b1;
    drive();
  endtask

  task automatic count_settle(output int n, output int g);
    n = 0;
    g = 0;
    while (settling && n < 1000) begin
      n++;
      if (grant_valid) g++;
      tick();
    end
  endtask

  initial begin
    int n, g;
    vecs[0]  = '{1'b0, 2'd0, 4'b0000, 1'b1, 1'b0, 2'd0};
    vecs[1]  = '{1'b0, 2'd0, 4'b0101, 1'b1, 1'b1, 2'd0};
    vecs[2]  = '{1'b0, 2'd0, 4'b1100, 1'b1, 1'b1, 2'd2};
    vecs[3]  = '{1'b0, 2'd0, 4'b1000, 1'b1, 1'b1, 2'd3};
    vecs[4]  = '{1'b0, 2'd0, 4'b1111, 1'b0, 1'b0, 2'd0};
    vecs[5]  = '{1'b1, 2'd0, 4'b1111, 1'b1, 1'b1, 2'd1};
    vecs[6]  = '{1'b1, 2'd2, 4'b1011, 1'b1, 1'b1, 2'd3};
    vecs[7]  = '{1'b1, 2'd3, 4'b0110, 1'b1, 1'b1, 2'd1};
    vecs[8]  = '{1'b1, 2'd1, 4'b0001, 1'b1, 1'b1, 2'd0};
    vecs[9]  = '{1'b1, 2'd2, 4'b0100, 1'b1, 1'b1, 2'd2};
    vecs[10] = '{1'b1, 2'd3, 4'b1000, 1'b1, 1'b1, 2'd3};

    do_reset();
    chk("reset_gv", grant_valid, 0);
    chk("reset_idx", grant_index, 0);
    chk("reset_settling", settling, 0);
    chk("reset_tvalid", m_axis_tvalid, 0);
    chk("reset_tready", s_axis_tready, 0);

    foreach (vecs[v]) begin
      do_reset();
      if (vecs[v].has_prev) begin
        push_frame(vecs[v].prev, 1, 8'h10, 1);
        repeat (3) tick();
      end
      m_axis_tready = 1'b0;
      enable = vecs[v].en;
      for (int s = 0; s < 4; s++) if (vecs[v].mask[s]) push_frame(s, 1, 8'(8'hA0 + s), 0);
      tick();
      #1;
      chk($sformatf("vec%0d_gv", v), grant_valid, vecs[v].exp_gv);
      chk($sformatf("vec%0d_idx", v), grant_index, vecs[v].exp_idx);
      chk($sformatf("vec%0d_mvalid", v), m_axis_tvalid, vecs[v].exp_gv);
      chk($sformatf("vec%0d_mdata", v), m_axis_tdata, vecs[v].exp_gv ? 8'hA0 + vecs[v].exp_idx : 8'h00);
      chk($sformatf("vec%0d_muser", v), m_axis_tuser, vecs[v].exp_gv && vecs[v].exp_idx[0]);
      chk($sformatf("vec%0d_sready", v), s_axis_tready, 0);
    end

    do_reset();
    push_frame(0, 4, 8'h00, 4);
    push_frame(2, 4, 8'h20, 4);
    tick();
    chk("s1_grant0_gv", grant_valid, 1);
    chk("s1_grant0_idx", grant_index, 0);
    repeat (4) tick();
    chk("s1_after_tlast_gv", grant_valid, 0);
    tick();
    chk("s1_grant2_gv", grant_valid, 1);
    chk("s1_grant2_idx", grant_index, 2);
    #1;
    chk("s1_src2_ready", s_axis_tready, 4'b0100);
    repeat (4) tick();
    chk("s1_drain", exp_q.size(), 0);

    do_reset();
    for (int r = 0; r < 12; r++) push_frame(r % 4, 1, 8'(8'h40 + r), 1);
    for (int r = 0; r < 12; r++) begin
      tick();
      chk($sformatf("s2_grant%0d_idx", r), grant_valid ? 32'(grant_index) : 32'hFF, r % 4);
      tick();
      chk($sformatf("s2_idle%0d", r), grant_valid, 0);
    end
    chk("s2_drain", exp_q.size(), 0);

    do_reset();
    push_frame(1, 10, 8'h60, 10);
    tick();
    chk("s3_grant_idx", grant_index, 1);
    repeat (2) tick();
    speed = 2'b01;
    repeat (7) tick();
    chk("s3_mid_gv", grant_valid, 1);
    chk("s3_mid_settling", settling, 0);
    tick();
    chk("s3_tlast_gv", grant_valid, 0);
    chk("s3_tlast_settling", settling, 1);
    push_frame(0, 1, 8'h70, 1);
    count_settle(n, g);
    chk("s3_settle_len", n, 256);
    chk("s3_settle_grants", g, 0);
    tick();
    chk("s3_post_gv", grant_valid, 1);
    chk("s3_post_idx", grant_index, 0);
    tick();
    chk("s3_drain", exp_q.size(), 0);

    do_reset();
    speed = 2'b00;
    push_frame(0, 1, 8'h80, 1);
    tick();
    chk("s4_settling", settling, 1);
    chk("s4_no_grant", grant_valid, 0);
    repeat (99) tick();
    chk("s4_settle_c100", settling, 1);
    speed = 2'b01;
    tick();
    count_settle(n, g);
    chk("s4_restart_len", n, 256);
    chk("s4_restart_grants", g, 0);
    tick();
    chk("s4_post_gv", grant_valid, 1);
    tick();
    chk("s4_drain", exp_q.size(), 0);

    do_reset();
    enable = 1'b0;
    push_frame(1, 3, 8'h90, 3);
    push_frame(2, 1, 8'h98, 0);
    g = 0;
    repeat (4) begin
      tick();
      if (grant_valid) g++;
    end
    chk("s5_disabled_grants", g, 0);
    enable = 1'b1;
    tick();
    chk("s5_grant_idx", grant_valid ? 32'(grant_index) : 32'hFF, 1);
    enable = 1'b0;
    repeat (3) tick();
    chk("s5_frame_done_gv", grant_valid, 0);
    g = 0;
    repeat (4) begin
      tick();
      if (grant_valid) g++;
    end
    chk("s5_no_more_grants", g, 0);
    chk("s5_drain", exp_q.size(), 0);

    do_reset();
    push_frame(3, 6, 8'hC0, 2);
    tick();
    chk("s6_grant_idx", grant_index, 3);
    repeat (2) tick();
    rst_n = 1'b0;
    tick();
    #1;
    chk("s6_rst_mvalid", m_axis_tvalid, 0);
    chk("s6_rst_sready", s_axis_tready, 0);
    chk("s6_rst_gv", grant_valid, 0);
    rst_n = 1'b1;
    src_q[3].delete();
    push_frame(0, 1, 8'hD0, 1);
    push_frame(3, 1, 8'hE0, 1);
    tick();
    chk("s6_prio_idx", grant_valid ? 32'(grant_index) : 32'hFF, 0);
    repeat (2) tick();
    chk("s6_next_idx", grant_valid ? 32'(grant_index) : 32'hFF, 3);
    tick();
    chk("s6_drain", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
